// File: rtl/pipe_ripple_adder.sv
// -----------------------------------------------------------------------------
// pipe_ripple_adder
//
// Pipelined ripple-carry adder. The N-bit add is cut into STAGES chunks of
// CHUNK = N/STAGES bits. Each chunk ripples through per-bit full adders in one
// cycle, and its carry out is registered into the next stage. Higher operand
// chunks travel down the pipe until their stage is reached. Lower sum chunks
// travel down with them, so the whole sum leaves in one cycle.
//
// Optional build macro: PIPE_ADDER_OVF_EN adds the 'ovf' output, which flags
// signed two's-complement overflow.
//
// Parameters:
//   N          operand/sum width
//   STAGES     pipeline depth; must divide N, 1 <= STAGES <= N
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin present this cycle
//   in_ready   block accepts an input this cycle
//   a, b       operands (N bits)
//   cin        carry in
//   out_valid  sum/cout valid
//   out_ready  downstream accepts the output
//   sum        registered sum (N bits)
//   cout       registered carry out
//   ovf        registered signed overflow (only with PIPE_ADDER_OVF_EN)
//
// Handshake: a beat moves on a clock edge when valid and ready are both high.
// The producer holds its data while valid && !ready. in_ready is combinational
// from the output side (adv = ~out_valid | out_ready), so the whole pipe
// advances or holds as one unit. Bubbles are carried along and are not
// collapsed.
// -----------------------------------------------------------------------------
module pipe_ripple_adder #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CHUNK = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipe_ripple_adder: STAGES must divide N and satisfy 1 <= STAGES <= N");
    end

    logic             adv;

    // Pipeline registers: one entry per stage.
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [N-1:0]     a_q   [STAGES];
    logic [N-1:0]     b_q   [STAGES];
    logic [N-1:0]     s_q   [STAGES];

    // Combinational stage inputs and results.
    logic [N-1:0]     op_a  [STAGES];
    logic [N-1:0]     op_b  [STAGES];
    logic [N-1:0]     s_in  [STAGES];
    logic             ci    [STAGES];
    logic [CHUNK-1:0] rs    [STAGES];
    logic             c_d   [STAGES];
    logic [N-1:0]     s_d   [STAGES];

    assign adv      = ~v_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign op_a[k] = a;
            assign op_b[k] = b;
            assign ci[k]   = cin;
            assign s_in[k] = '0;
        end else begin : g_next
            assign op_a[k] = a_q[k-1];
            assign op_b[k] = b_q[k-1];
            assign ci[k]   = c_q[k-1];
            assign s_in[k] = s_q[k-1];
        end

        // Per-bit full-adder ripple across this stage's chunk.
        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            logic x;
            logic y;
            logic c;
            logic co;
            assign x = op_a[k][k*CHUNK + i];
            assign y = op_b[k][k*CHUNK + i];
            if (i == 0) begin : g_lsb
                assign c = ci[k];
            end else begin : g_chain
                assign c = g_bit[i-1].co;
            end
            assign rs[k][i] = x ^ y ^ c;
            assign co       = (x & y) | (c & (x ^ y));
        end

        assign c_d[k] = g_bit[CHUNK-1].co;
        // Only chunks below k are filled in s_in, so OR-ing in chunk k is
        // the same as inserting it.
        assign s_d[k] = s_in[k] | (N'(rs[k]) << (k*CHUNK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= op_a[k];
                b_q[k] <= op_b[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = g_stage[STAGES-1].g_bit[CHUNK-1].c ^ c_d[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
module tb_pipe_ripple_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 8-bit, 2-stage DUT ----------------
    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef PIPE_ADDER_OVF_EN
    logic       ovf8;
`endif

    pipe_ripple_adder #(.N(8), .STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // ---------------- 16-bit sweep DUTs: STAGES = 1, 4, 16 ----------------
    logic        in_valid16, cin16;
    logic        out_ready16;
    logic [15:0] a16, b16;
    logic        in_ready16 [3];
    logic        out_valid16 [3];
    logic        cout16 [3];
    logic [15:0] sum16 [3];
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf16 [3];
`endif

    pipe_ripple_adder #(.N(16), .STAGES(1)) u16_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16[0]),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16[0]), .out_ready(out_ready16),
        .sum(sum16[0]), .cout(cout16[0])
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16[0])
`endif
    );

    pipe_ripple_adder #(.N(16), .STAGES(4)) u16_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16[1]),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16[1]), .out_ready(out_ready16),
        .sum(sum16[1]), .cout(cout16[1])
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16[1])
`endif
    );

    pipe_ripple_adder #(.N(16), .STAGES(16)) u16_s16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16[2]),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16[2]), .out_ready(out_ready16),
        .sum(sum16[2]), .cout(cout16[2])
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16[2])
`endif
    );

    // ---------------- reference models ----------------
    // {ovf, cout, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int u;
        int s;
        logic [9:0] r;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        r[7:0] = u[7:0];
        r[8]   = u[8];
        r[9]   = (s > 127) || (s < -128);
        return r;
    endfunction

    // {ovf, cout, sum[15:0]}
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        int u;
        int s;
        logic [17:0] r;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        r[15:0] = u[15:0];
        r[16]   = u[16];
        r[17]   = (s > 32767) || (s < -32768);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [9:0]  exp8_q [$];
    logic [49:0] sweep_q [$];   // {accept cycle, ovf, cout, sum}
    int          rd_ptr [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on the 8-bit DUT: drive, score at the falling edge, step.
    task automatic cycle8(input logic v, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic rdy);
        logic [9:0] e;
        in_valid8 = v; a8 = x; b8 = y; cin8 = c; out_ready8 = rdy;
        @(negedge clk);
        if (out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb8_extra: got output sum=%0h with nothing expected", sum8);
            end else begin
                e = exp8_q.pop_front();
                check("sb8_sum", 64'(sum8), 64'(e[7:0]));
                check("sb8_cout", 64'(cout8), 64'(e[8]));
`ifdef PIPE_ADDER_OVF_EN
                check("sb8_ovf", 64'(ovf8), 64'(e[9]));
`endif
            end
        end
        if (v && in_ready8) exp8_q.push_back(model8(x, y, c));
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input int id, input int stg);
        logic [49:0] e;
        if (out_valid16[id]) begin
            if (rd_ptr[id] >= sweep_q.size()) begin
                n_checks++;
                n_fail++;
                $display("FAIL sweep_extra[S=%0d]: got output sum=%0h with nothing expected", stg, sum16[id]);
            end else begin
                e = sweep_q[rd_ptr[id]];
                rd_ptr[id]++;
                check($sformatf("sweep_sum[S=%0d]", stg), 64'(sum16[id]), 64'(e[15:0]));
                check($sformatf("sweep_cout[S=%0d]", stg), 64'(cout16[id]), 64'(e[16]));
`ifdef PIPE_ADDER_OVF_EN
                check($sformatf("sweep_ovf[S=%0d]", stg), 64'(ovf16[id]), 64'(e[17]));
`endif
                check($sformatf("sweep_latency[S=%0d]", stg), 64'(cyc - int'(e[49:18])), 64'(stg));
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] e0;
        int         n_sent;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tbl[2] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};

        rst_n = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
        for (int i = 0; i < 3; i++) rd_ptr[i] = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid8), 64'(0));
        check("rst_sum", 64'(sum8), 64'(0));
        check("rst_cout", 64'(cout8), 64'(0));
        check("rst_in_ready", 64'(in_ready8), 64'(1));
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", 64'(ovf8), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven back-to-back stream: result i appears in cycle i+2
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                in_valid8 = 1'b1; a8 = tbl[i].a; b8 = tbl[i].b; cin8 = tbl[i].cin;
            end else begin
                in_valid8 = 1'b0;
            end
            out_ready8 = 1'b1;
            @(negedge clk);
            check($sformatf("tbl_valid[%0d]", i), 64'(out_valid8), 64'(i >= 2));
            check($sformatf("tbl_in_ready[%0d]", i), 64'(in_ready8), 64'(1));
            if (i >= 2) begin
                check($sformatf("tbl_sum[%0d]", i - 2), 64'(sum8), 64'(tbl[i-2].sum));
                check($sformatf("tbl_cout[%0d]", i - 2), 64'(cout8), 64'(tbl[i-2].cout));
`ifdef PIPE_ADDER_OVF_EN
                check($sformatf("tbl_ovf[%0d]", i - 2), 64'(ovf8), 64'(tbl[i-2].ovf));
`endif
            end
            @(posedge clk);
            #1;
        end

        // Backpressure: fill, stall 3 cycles with garbage inputs, then drain
        e0 = model8(8'h12, 8'h34, 1'b1);
        cycle8(1'b1, 8'h12, 8'h34, 1'b1, 1'b1);
        cycle8(1'b1, 8'hF0, 8'h0F, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            out_ready8 = 1'b0;
            @(negedge clk);
            check($sformatf("stall_in_ready[%0d]", j), 64'(in_ready8), 64'(0));
            check($sformatf("stall_out_valid[%0d]", j), 64'(out_valid8), 64'(1));
            check($sformatf("stall_sum[%0d]", j), 64'(sum8), 64'(e0[7:0]));
            check($sformatf("stall_cout[%0d]", j), 64'(cout8), 64'(e0[8]));
            @(posedge clk);
            #1;
        end
        cycle8(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("stall_drain_empty", 64'(exp8_q.size()), 64'(0));

        // Random traffic with bubbles and random backpressure
        for (int i = 0; i < 200; i++) begin
            cycle8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("rand8_drain_empty", 64'(exp8_q.size()), 64'(0));

        // Reset mid-stream with two results in flight
        cycle8(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        cycle8(1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
        check("pre_reset_out_valid", 64'(out_valid8), 64'(1));
        in_valid8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid8), 64'(0));
        check("midrst_sum", 64'(sum8), 64'(0));
        check("midrst_cout", 64'(cout8), 64'(0));
        exp8_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'b0; out_ready8 = 1'b1;
            @(negedge clk);
            check($sformatf("post_rst_idle[%0d]", i), 64'(out_valid8), 64'(0));
            @(posedge clk);
            #1;
        end
        cycle8(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b1);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("post_rst_first_result", 64'(exp8_q.size()), 64'(0));

        // 16-bit sweep, STAGES = 1/4/16, random vectors with bubbles
        n_sent = 0;
        while (n_sent < 1000) begin
            in_valid16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
            @(negedge clk);
            sweep_check(0, 1);
            sweep_check(1, 4);
            sweep_check(2, 16);
            if (in_valid16) begin
                sweep_q.push_back({32'(cyc), model16(a16, b16, cin16)});
                n_sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid16 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sweep_check(0, 1);
            sweep_check(1, 4);
            sweep_check(2, 16);
            @(posedge clk);
            #1;
        end
        check("sweep_done[S=1]", 64'(rd_ptr[0]), 64'(sweep_q.size()));
        check("sweep_done[S=4]", 64'(rd_ptr[1]), 64'(sweep_q.size()));
        check("sweep_done[S=16]", 64'(rd_ptr[2]), 64'(sweep_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ripple_adder.md
Name: pipe_ripple_adder

Overview:
- Parametrised, pipelined successor to the team's structural ripple-carry adder.
- Splits an N-bit add into STAGES equal chunks; each chunk ripples in one cycle, and its carry is registered into the next stage.
- Operands travel with a valid/ready handshake, so the block drops into streaming datapaths (accumulators, MAC tails) at higher clock rates than a flat ripple chain.

Parameters:
- N, 8, operand/sum width in bits.
- STAGES, 2, number of pipeline stages. Must divide N exactly, with 1 <= STAGES <= N. Illegal values stop elaboration through a generate-time check.
- CHUNK, derived N/STAGES (localparam), bits added per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/cin present this cycle
- in_ready  output  1  block accepts an input this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry in
- out_valid  output  1  sum/cout valid
- out_ready  input  1  downstream accepts the output
- sum  output  N  registered sum
- cout  output  1  registered carry out

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits, sum, cout and every internal carry/operand/partial-sum register clear to 0. out_valid=0. in_ready follows the advance rule below, so it is 1 during reset.
- Stage k (0..STAGES-1):
  - Adds a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + carry_k.
  - carry_0 = cin. carry_k for k>0 is the registered carry out of stage k-1.
  - The CHUNK-bit addition is a chained per-bit full-adder ripple inside the stage, generated with a for-generate loop.
- Skew registers:
  - Higher operand chunks are delayed so each chunk reaches its stage in the same cycle as its carry.
  - Lower sum chunks are delayed so all chunks leave together.
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinationally.
  - When adv=1, every stage register shifts one step. Stage-0 valid loads in_valid.
  - When adv=0, all registers hold, including data and valid bits.
- A transfer occurs when in_valid & in_ready. Output is consumed when out_valid & out_ready.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stalls. With no backpressure, throughput is 1 result per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as invalid slots. Bubbles are not collapsed.
- STAGES=1: single registered ripple adder, latency 1.
- STAGES=N: one bit per stage.
- Simultaneous consume and accept: allowed in the same cycle, and the pipeline keeps full throughput.
- Inputs are sampled only on an accepted transfer. Changing a/b while in_ready=0 has no effect.
- Wrap-around: sum is modulo 2^N; cout is bit N of a+b+cin.
- Reset mid-operation: all in-flight results are discarded. The first valid output after reset belongs to the first input accepted after rst_n deasserts.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, taken from the last stage.
  - ovf is registered and aligned with sum/cout, held under stall, and reset to 0.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
- N=8, STAGES=2, out_ready=1. Send a=0xFF, b=0x01, cin=0 → 2 cycles later out_valid=1, sum=0x00, cout=1.
- Back-to-back stream (0x12+0x34 cin=1, then 0xF0+0x0F cin=0, then 0x80+0x80 cin=0) → consecutive cycles give sum=0x47 cout=0, sum=0xFF cout=0, sum=0x00 cout=1.
- Backpressure:
  - Fill the pipe, then hold out_ready=0 for 3 cycles → in_ready=0 and out_valid=1 throughout, with sum/cout stable.
  - Release out_ready → results drain in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 asynchronously (between clock edges) with 2 results in flight → out_valid, sum and cout drop to 0 immediately. After release, no stale results appear.
- PIPE_ADDER_OVF_EN defined, N=8:
  - a=0x7F, b=0x01 → sum=0x80, ovf=1.
  - a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0.
- Parameter sweep N=16 with STAGES=1, 4 and 16: 1000 random vectors checked against a+b+cin. Latency equals STAGES in every case.
